// File: rtl/ofdm_cp_inserter.sv
// Buffers one IFFT symbol in RAM and replays it with a cyclic prefix.
// Define OFDM_CP_INSERTER_STATS_EN to add the sym_cnt/err_cnt counters.
module ofdm_cp_inserter #(
  parameter int NFFT   = 4096,
  parameter int CP_LEN = 256,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              frame_err
`ifdef OFDM_CP_INSERTER_STATS_EN
  ,
  output logic [15:0]       sym_cnt,
  output logic [7:0]        err_cnt
`endif
);

  localparam int AW = $clog2(NFFT);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_A = AW'(NFFT - 1);
  localparam logic [AW-1:0] CP_OFF = AW'(NFFT - CP_LEN);
  localparam logic [CW-1:0] TOT_C  = CW'(CP_LEN + NFFT);
  localparam logic [CW-1:0] TOT_M1 = CW'(CP_LEN + NFFT - 1);
  localparam logic [CW-1:0] CP_M1  = CW'(CP_LEN - 1);

  typedef enum logic [1:0] {
    FILL,
    PAD,
    CP,
    BODY
  } state_t;

  state_t state_q, state_n;

  logic [DATA_W-1:0] mem [NFFT];

  logic [AW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] out_cnt;
  logic          burst_end;
  logic          s_rdy_q;
  logic          err_q;

  logic [DATA_W-1:0] sk_data [2];
  logic [1:0]        sk_last;
  logic              sk_wp;
  logic              sk_rp;
  logic [1:0]        sk_cnt;

  logic              in_acc;
  logic              pop;
  logic              rd_act;
  logic              issue;
  logic              beat_last;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [AW-1:0]     rd_addr;

  assign s_axis_tready = s_rdy_q;
  assign frame_err     = err_q;
  assign m_axis_tvalid = (sk_cnt != 2'd0);
  assign m_axis_tdata  = sk_data[sk_rp];
  assign m_axis_tlast  = sk_last[sk_rp];

  assign in_acc    = s_axis_tvalid & s_rdy_q;
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign beat_last = (out_cnt == TOT_M1);

  // CP and body share one counter; mod-NFFT addressing covers both.
  assign rd_addr = AW'(rd_cnt) + CP_OFF;
  assign rd_act  = ((state_q == CP) || (state_q == BODY))
                   && (rd_cnt != TOT_C);
  assign issue   = rd_act && ((sk_cnt != 2'd2) || pop);

  assign mem_we = in_acc || (state_q == PAD);
  assign mem_wd = (state_q == PAD) ? '0 : s_axis_tdata;

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      FILL: begin
        if (in_acc) begin
          if (wr_cnt == LAST_A) state_n = CP;
          else if (s_axis_tlast) state_n = PAD;
        end
      end
      PAD: begin
        if (wr_cnt == LAST_A) state_n = CP;
      end
      CP: begin
        if (pop && (out_cnt == CP_M1)) state_n = BODY;
      end
      BODY: begin
        if (pop && beat_last) state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[wr_cnt] <= mem_wd;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= FILL;
      s_rdy_q   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_cnt   <= '0;
      burst_end <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_n;
      s_rdy_q <= (state_n == FILL);
      if (in_acc) begin
        wr_cnt <= wr_cnt + AW'(1);
        if (wr_cnt == LAST_A) begin
          burst_end <= s_axis_tlast;
        end else if (s_axis_tlast) begin
          burst_end <= 1'b1;
          err_q     <= 1'b1;
        end
      end
      if (state_q == PAD) wr_cnt <= wr_cnt + AW'(1);
      if (issue) rd_cnt <= rd_cnt + CW'(1);
      if (pop) out_cnt <= out_cnt + CW'(1);
      if ((state_q == BODY) && (state_n == FILL)) begin
        wr_cnt    <= '0;
        rd_cnt    <= '0;
        out_cnt   <= '0;
        burst_end <= 1'b0;
      end
    end
  end

  // Two-entry skid buffer fed straight by the registered RAM read.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sk_data[0] <= '0;
      sk_data[1] <= '0;
      sk_last    <= '0;
      sk_wp      <= 1'b0;
      sk_rp      <= 1'b0;
      sk_cnt     <= '0;
    end else begin
      if (issue) begin
        sk_data[sk_wp] <= mem[rd_addr];
        sk_last[sk_wp] <= burst_end && (rd_cnt == TOT_M1);
        sk_wp          <= ~sk_wp;
      end
      if (pop) sk_rp <= ~sk_rp;
      unique case ({issue, pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase
    end
  end

`ifdef OFDM_CP_INSERTER_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      sym_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (pop && beat_last) sym_cnt <= sym_cnt + 16'd1;
      if ((state_q == FILL) && (state_n == PAD)
          && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Scoreboard bench for ofdm_cp_inserter: small (16/4) and default instances.
// Stats ports are exercised when OFDM_CP_INSERTER_STATS_EN is defined.
`timescale 1ns/1ps
module tb_ofdm_cp_inserter;
  localparam int N   = 16;
  localparam int CP  = 4;
  localparam int TOT = N + CP;
  localparam int NB  = 4096;
  localparam int CPB = 256;
  localparam int TOTB = NB + CPB;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic        areset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        frame_err;

  logic        rst_b = 1'b1;
  logic [31:0] sb_tdata = '0;
  logic        sb_tvalid = 1'b0;
  logic        sb_tlast = 1'b0;
  logic        sb_tready;
  logic [31:0] mb_tdata;
  logic        mb_tvalid;
  logic        mb_tready = 1'b1;
  logic        mb_tlast;
  logic        frame_err_b;

`ifdef OFDM_CP_INSERTER_STATS_EN
  logic [15:0] sym_cnt, sym_cnt_b;
  logic [7:0]  err_cnt, err_cnt_b;
`endif

  ofdm_cp_inserter #(.NFFT(N), .CP_LEN(CP), .DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .frame_err(frame_err)
`ifdef OFDM_CP_INSERTER_STATS_EN
    , .sym_cnt(sym_cnt), .err_cnt(err_cnt)
`endif
  );

  ofdm_cp_inserter dut_b (
    .aclk(aclk), .areset(rst_b),
    .s_axis_tdata(sb_tdata), .s_axis_tvalid(sb_tvalid),
    .s_axis_tready(sb_tready), .s_axis_tlast(sb_tlast),
    .m_axis_tdata(mb_tdata), .m_axis_tvalid(mb_tvalid),
    .m_axis_tready(mb_tready), .m_axis_tlast(mb_tlast),
    .frame_err(frame_err_b)
`ifdef OFDM_CP_INSERTER_STATS_EN
    , .sym_cnt(sym_cnt_b), .err_cnt(err_cnt_b)
`endif
  );

  beat_t exp_a[$];
  beat_t exp_b[$];
  beat_t ea, eb;
  logic [31:0] sym [N];
  int popped_a = 0;
  int popped_b = 0;
  int acc_cyc = 0;
  int rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  function automatic logic [31:0] iq(input int k);
    return {16'(-k), 16'(k)};
  endfunction

  // Scoreboard push for one small-instance symbol.
  task automatic exp_sym_a(input logic bl);
    for (int i = 0; i < TOT; i++) begin
      int idx;
      idx = (i < CP) ? (N - CP + i) : (i - CP);
      exp_a.push_back('{d: sym[idx], l: bl && (i == TOT - 1)});
    end
  endtask

  task automatic push_a(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_tdata = d;
    s_tvalid = 1'b1;
    s_tlast = l;
    while (!s_tready && n < 2000) begin
      tick();
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL push_a_timeout: s_axis_tready 0, required 1");
    end
    acc_cyc = cyc;
    tick();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    sb_tdata = d;
    sb_tvalid = 1'b1;
    sb_tlast = l;
    while (!sb_tready && n < 10000) begin
      tick();
      n++;
    end
    if (!sb_tready) begin
      checks++;
      errors++;
      $display("FAIL push_b_timeout: s_axis_tready 0, required 1");
    end
    tick();
    sb_tvalid = 1'b0;
    sb_tlast = 1'b0;
  endtask

  task automatic drain_a(input string nm);
    int n;
    n = 0;
    while (exp_a.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, 64'(exp_a.size()), 64'd0);
    repeat (3) tick();
    chk({nm, "_idle_valid"}, m_tvalid, 1'b0);
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (rdy_mode == 1) m_tready = ~m_tready;
      else m_tready = 1'b1;
    end
  end

  logic        stall_a = 1'b0;
  logic [31:0] pd_a;
  logic        pl_a;

  always @(negedge aclk) begin
    if (areset) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        chk("hold_valid", m_tvalid, 1'b1);
        chk("hold_data", m_tdata, pd_a);
        chk("hold_last", m_tlast, pl_a);
      end
      if (m_tvalid) chk("s_ready_low_during_output", s_tready, 1'b0);
      if (m_tvalid && m_tready) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %0h, required no beat", m_tdata);
        end else begin
          ea = exp_a.pop_front();
          chk("beat_data", m_tdata, ea.d);
          chk("beat_last", m_tlast, ea.l);
        end
        popped_a++;
      end
      stall_a = m_tvalid && !m_tready;
      pd_a = m_tdata;
      pl_a = m_tlast;
    end
  end

  always @(negedge aclk) begin
    if (!rst_b && mb_tvalid && mb_tready) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL big_extra_beat: got %0h, required no beat", mb_tdata);
      end else begin
        eb = exp_b.pop_front();
        chk("big_data", mb_tdata, eb.d);
        chk("big_last", mb_tlast, eb.l);
      end
      popped_b++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
`ifdef OFDM_CP_INSERTER_STATS_EN
    logic [15:0] sc0;
`endif
    repeat (3) tick();
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tdata", m_tdata, 32'h0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    areset = 1'b0;
    rst_b = 1'b0;
    tick();
    chk("s_tready_after_reset", s_tready, 1'b1);

    // Single burst, ready held high, latency checked
    for (int k = 0; k < N; k++) sym[k] = iq(k);
    exp_sym_a(1'b1);
    for (int k = 0; k < N; k++) push_a(sym[k], k == N - 1);
    chk("latency_minus1_valid", m_tvalid, 1'b0);
    tick();
    chk("latency_cyc", 64'(cyc - acc_cyc), 64'd2);
    chk("latency_valid", m_tvalid, 1'b1);
    drain_a("t1");
    chk("t1_frame_err", frame_err, 1'b0);

    // Same symbol with downstream stalls every other cycle
    rdy_mode = 1;
    exp_sym_a(1'b1);
    for (int k = 0; k < N; k++) push_a(sym[k], k == N - 1);
    drain_a("t2");
    rdy_mode = 0;

    // Two back-to-back symbols, burst ends on the second
    for (int k = 0; k < N; k++) sym[k] = iq(k + 100);
    exp_sym_a(1'b0);
    for (int k = 0; k < N; k++) push_a(sym[k], 1'b0);
    for (int k = 0; k < N; k++) sym[k] = iq(k + 200);
    exp_sym_a(1'b1);
    for (int k = 0; k < N; k++) push_a(sym[k], k == N - 1);
    drain_a("t3");
    chk("t3_frame_err", frame_err, 1'b0);

    // Short burst of 10 samples, zero-padded
`ifdef OFDM_CP_INSERTER_STATS_EN
    sc0 = sym_cnt;
`endif
    for (int k = 0; k < N; k++) sym[k] = (k < 10) ? iq(k + 1) : 32'h0;
    exp_sym_a(1'b1);
    for (int k = 0; k < 10; k++) push_a(sym[k], k == 9);
    drain_a("t4");
    chk("t4_frame_err", frame_err, 1'b1);
`ifdef OFDM_CP_INSERTER_STATS_EN
    chk("t4_err_cnt", err_cnt, 8'd1);
    chk("t4_sym_cnt_delta", 16'(sym_cnt - sc0), 16'd1);
`endif

    // Reset in the middle of the body
    for (int k = 0; k < N; k++) sym[k] = iq(k + 50);
    exp_sym_a(1'b1);
    p0 = popped_a;
    for (int k = 0; k < N; k++) push_a(sym[k], k == N - 1);
    n = 0;
    while (popped_a < p0 + CP + 8 && n < 500) begin
      tick();
      n++;
    end
    chk("t5_reached_body", 64'(popped_a - p0), 64'(CP + 8));
    areset = 1'b1;
    exp_a.delete();
    tick();
    areset = 1'b0;
    chk("t5_valid_after_reset", m_tvalid, 1'b0);
    chk("t5_ready_after_reset", s_tready, 1'b0);
    tick();
    chk("t5_ready_rises", s_tready, 1'b1);
    chk("t5_frame_err_cleared", frame_err, 1'b0);
`ifdef OFDM_CP_INSERTER_STATS_EN
    chk("t5_err_cnt_cleared", err_cnt, 8'd0);
    chk("t5_sym_cnt_cleared", sym_cnt, 16'd0);
`endif
    for (int k = 0; k < N; k++) sym[k] = iq(k);
    exp_sym_a(1'b1);
    for (int k = 0; k < N; k++) push_a(sym[k], k == N - 1);
    drain_a("t5");
    chk("t5_frame_err", frame_err, 1'b0);

    // Default-size instance: two ramp symbols
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < TOTB; i++) begin
        int idx;
        idx = (i < CPB) ? (NB - CPB + i) : (i - CPB);
        exp_b.push_back('{d: 32'(s * NB + idx),
                          l: (s == 1) && (i == TOTB - 1)});
      end
    end
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < NB; k++)
        push_b(32'(s * NB + k), (s == 1) && (k == NB - 1));
    n = 0;
    while (exp_b.size() != 0 && n < 10000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("big_beats", 64'(popped_b), 64'(2 * TOTB));
    chk("big_frame_err", frame_err_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
